// File: rtl/md5_search_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : md5_search_engine                                      |
// | Description : Iterative MD5 preimage search. Walks candidates of     |
// |               MSG_LEN bytes over [CHAR_MIN, CHAR_MAX], one MD5 step  |
// |               per clock, and stops on a digest match or when the     |
// |               range is exhausted.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module md5_search_engine #(
  parameter int         MSG_LEN  = 6,
  parameter logic [7:0] CHAR_MIN = 8'h61,
  parameter logic [7:0] CHAR_MAX = 8'h7a
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*MSG_LEN-1:0]   init_msg,
  input  logic [127:0]           target,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [8*MSG_LEN-1:0]   match_msg
);

  localparam logic [31:0] c_iv_a = 32'h67452301;
  localparam logic [31:0] c_iv_b = 32'hefcdab89;
  localparam logic [31:0] c_iv_c = 32'h98badcfe;
  localparam logic [31:0] c_iv_d = 32'h10325476;

  localparam logic [31:0] c_t [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [5:0]           r_step;
  logic [31:0]          r_a, r_b, r_c, r_d;
  logic [8*MSG_LEN-1:0] r_cand;
  logic [127:0]         r_target;

  logic [31:0]          w_x [16];
  logic [31:0]          w_f;
  logic [3:0]           w_g;
  logic [4:0]           w_s;
  logic [31:0]          w_sum;
  logic [63:0]          w_rot;
  logic [31:0]          w_bnew;
  logic                 w_match;
  logic                 w_last;
  logic [8*MSG_LEN-1:0] w_next;

  // Padded single-block message built from the current candidate; the
  // candidate is stable from LOAD through CHECK, so the block is too.
  always_comb begin
    logic [511:0] v_blk;
    v_blk = '0;
    for (int b = 0; b < MSG_LEN; b++) begin
      v_blk[8*b +: 8] = r_cand[8*b +: 8];
    end
    v_blk[8*MSG_LEN +: 8] = 8'h80;
    v_blk[14*32 +: 32]    = 32'(MSG_LEN * 8);
    for (int w = 0; w < 16; w++) begin
      w_x[w] = v_blk[32*w +: 32];
    end
  end

  // Round function and message word index for the current step
  always_comb begin
    w_f = '0;
    w_g = '0;
    case (r_step[5:4])
      2'd0: begin
        w_f = (r_b & r_c) | (~r_b & r_d);
        w_g = r_step[3:0];
      end
      2'd1: begin
        w_f = (r_b & r_d) | (r_c & ~r_d);
        w_g = r_step[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        w_f = r_b ^ r_c ^ r_d;
        w_g = r_step[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        w_f = r_c ^ (r_b | ~r_d);
        w_g = r_step[3:0] * 4'd7;
      end
    endcase
  end

  // Per-step left-rotate amount, selected by round and step mod 4
  always_comb begin
    w_s = 5'd7;
    case ({r_step[5:4], r_step[1:0]})
      4'h0: w_s = 5'd7;   4'h1: w_s = 5'd12;  4'h2: w_s = 5'd17;  4'h3: w_s = 5'd22;
      4'h4: w_s = 5'd5;   4'h5: w_s = 5'd9;   4'h6: w_s = 5'd14;  4'h7: w_s = 5'd20;
      4'h8: w_s = 5'd4;   4'h9: w_s = 5'd11;  4'ha: w_s = 5'd16;  4'hb: w_s = 5'd23;
      4'hc: w_s = 5'd6;   4'hd: w_s = 5'd10;  4'he: w_s = 5'd15;  default: w_s = 5'd21;
    endcase
  end

  // New B value; rotation done by shifting a doubled word and keeping the top half
  always_comb begin
    w_sum  = r_a + w_f + w_x[w_g] + c_t[r_step];
    w_rot  = {w_sum, w_sum} << w_s;
    w_bnew = r_b + w_rot[63:32];
  end

  // Final digest comparison, all four words
  always_comb begin
    w_match = ({r_d + c_iv_d, r_c + c_iv_c, r_b + c_iv_b, r_a + c_iv_a} == r_target);
  end

  // Odometer increment of the candidate, byte 0 least significant
  always_comb begin
    logic v_carry;
    v_carry = 1'b1;
    w_last  = 1'b1;
    w_next  = r_cand;
    for (int j = 0; j < MSG_LEN; j++) begin
      if (r_cand[8*j +: 8] != CHAR_MAX) w_last = 1'b0;
      if (v_carry) begin
        if (r_cand[8*j +: 8] == CHAR_MAX) begin
          w_next[8*j +: 8] = CHAR_MIN;
        end else begin
          w_next[8*j +: 8] = r_cand[8*j +: 8] + 8'd1;
          v_carry          = 1'b0;
        end
      end
    end
  end

  // Search controller with registered status outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_cand    <= '0;
      r_target  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      match_msg <= '0;
    end else begin
      done <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        // Cancel leaves found/match_msg as they were and never pulses done
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_target <= target;
              r_cand   <= init_msg;
              found    <= 1'b0;
              busy     <= 1'b1;
              r_state  <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_a     <= c_iv_a;
            r_b     <= c_iv_b;
            r_c     <= c_iv_c;
            r_d     <= c_iv_d;
            r_step  <= '0;
            r_state <= S_ROUND;
          end
          S_ROUND: begin
            r_a    <= r_d;
            r_b    <= w_bnew;
            r_c    <= r_b;
            r_d    <= r_c;
            r_step <= r_step + 6'd1;
            if (r_step == 6'd63) r_state <= S_CHECK;
          end
          S_CHECK: begin
            if (w_match || w_last) begin
              found     <= w_match;
              match_msg <= r_cand;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_cand  <= w_next;
              r_state <= S_LOAD;
            end
          end
          S_DONE: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md5_search_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_md5_search_engine                                   |
// | Description : Scoreboard bench for md5_search_engine; three          |
// |               instances (MSG_LEN 6, 3, 1) exercised one at a time.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_md5_search_engine;

  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // instance 0: MSG_LEN=6
  logic         start6 = 0, abort6 = 0, busy6, done6, found6;
  logic [47:0]  init6 = '0, msg6;
  logic [127:0] tgt6 = '0;
  // instance 1: MSG_LEN=3
  logic         start3 = 0, abort3 = 0, busy3, done3, found3;
  logic [23:0]  init3 = '0, msg3;
  logic [127:0] tgt3 = '0;
  // instance 2: MSG_LEN=1
  logic         start1 = 0, abort1 = 0, busy1, done1, found1;
  logic [7:0]   init1 = '0, msg1;
  logic [127:0] tgt1 = '0;

  md5_search_engine #(.MSG_LEN(6)) u_dut6 (
    .Clk(Clk), .Rst_n(rst_n), .start(start6), .abort(abort6), .init_msg(init6),
    .target(tgt6), .busy(busy6), .done(done6), .found(found6), .match_msg(msg6));
  md5_search_engine #(.MSG_LEN(3)) u_dut3 (
    .Clk(Clk), .Rst_n(rst_n), .start(start3), .abort(abort3), .init_msg(init3),
    .target(tgt3), .busy(busy3), .done(done3), .found(found3), .match_msg(msg3));
  md5_search_engine #(.MSG_LEN(1)) u_dut1 (
    .Clk(Clk), .Rst_n(rst_n), .start(start1), .abort(abort1), .init_msg(init1),
    .target(tgt1), .busy(busy1), .done(done1), .found(found1), .match_msg(msg1));

  // Digests packed {D, C, B, A}
  localparam logic [127:0] c_md5_aaaaaa = {32'h79acee9c, 32'h5bf9b55f, 32'hd34ae85f, 32'h0e7a4e0b};
  localparam logic [127:0] c_md5_abc    = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  localparam logic [127:0] c_md5_a      = {32'h61267769, 32'he299c331, 32'ha8b6f1c0, 32'hb975c10c};

  typedef struct {
    int          dut;
    int          edge_n;
    logic        found;
    logic [63:0] msg;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Pop the oldest expectation and compare it against a done pulse
  task automatic check_done(input int id, input logic f, input logic [63:0] m);
    exp_t e;
    if (sb.size() == 0 || sb[0].dut != id) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_done: got done on dut%0d expected none (edge %0d)", id, cyc + 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("done_edge_dut%0d", id), 64'(cyc + 1), 64'(e.edge_n));
      chk($sformatf("found_dut%0d", id), {63'd0, f}, {63'd0, e.found});
      chk($sformatf("match_msg_dut%0d", id), m, e.msg);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge Clk) begin
    if (rst_n) begin
      if (done6) check_done(0, found6, {16'd0, msg6});
      if (done3) check_done(1, found3, {40'd0, msg3});
      if (done1) check_done(2, found1, {56'd0, msg1});
    end
  end

  // Issue a one-cycle start; e0 is the edge that samples it
  task automatic issue(input int id, input logic [63:0] init, input logic [127:0] tgt,
                       input bit push, input int k, input logic f, input logic [63:0] m,
                       output int e0);
    exp_t e;
    @(negedge Clk);
    e0 = cyc + 1;
    case (id)
      0: begin start6 = 1; init6 = init[47:0]; tgt6 = tgt; end
      1: begin start3 = 1; init3 = init[23:0]; tgt3 = tgt; end
      default: begin start1 = 1; init1 = init[7:0]; tgt1 = tgt; end
    endcase
    if (push) begin
      e.dut = id; e.edge_n = e0 + 67 + 66 * k; e.found = f; e.msg = m;
      sb.push_back(e);
    end
    @(negedge Clk);
    start6 = 0; start3 = 0; start1 = 0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic wait_until(input int edge_n);
    while (cyc < edge_n) @(negedge Clk);
  endtask

  initial begin
    int e0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_busy", {63'd0, busy6}, 64'd0);
    chk("rst_done", {63'd0, done6}, 64'd0);
    chk("rst_found", {63'd0, found6}, 64'd0);
    chk("rst_match_msg", {16'd0, msg6}, 64'd0);
    rst_n = 1;
    repeat (2) @(negedge Clk);

    // Direct hit "aaaaaa"; a start pulse during ROUND must be ignored
    issue(0, 64'h616161616161, c_md5_aaaaaa, 1, 0, 1'b1, 64'h616161616161, e0);
    chk("busy_running", {63'd0, busy6}, 64'd1);
    wait_until(e0 + 30);
    start6 = 1; init6 = 48'h7a7a7a7a7a7a; tgt6 = 128'd0;
    @(negedge Clk);
    start6 = 0;
    wait_drain(200);
    chk("busy_after_done", {63'd0, busy6}, 64'd0);
    chk("found_held", {63'd0, found6}, 64'd1);

    // Carry across bytes: "yac" -> "zac" -> "abc"
    issue(1, 64'h636179, c_md5_abc, 1, 2, 1'b1, 64'h636261, e0);
    wait_drain(400);

    // Single-character hit
    issue(2, 64'h61, c_md5_a, 1, 0, 1'b1, 64'h61, e0);
    wait_drain(200);

    // Exhaustion of a 1-byte space starting at 'a'
    issue(2, 64'h61, 128'd0, 1, 25, 1'b0, 64'h7a, e0);
    wait_drain(2000);

    // Starting at the last candidate: exactly one candidate tested
    issue(2, 64'h7a, 128'd0, 1, 0, 1'b0, 64'h7a, e0);
    wait_drain(200);

    // Abort mid-search: no done, found cleared by start, match_msg unchanged
    issue(0, 64'h616161616161, 128'd0, 0, 0, 1'b0, 64'd0, e0);
    wait_until(e0 + 499);
    abort6 = 1;
    @(negedge Clk);
    abort6 = 0;
    chk("abort_busy", {63'd0, busy6}, 64'd0);
    repeat (100) @(negedge Clk);
    chk("abort_found", {63'd0, found6}, 64'd0);
    chk("abort_match_msg", {16'd0, msg6}, 64'h616161616161);

    // Abort alone in IDLE does nothing; start and abort together: start wins
    abort6 = 1;
    @(negedge Clk);
    chk("idle_abort_busy", {63'd0, busy6}, 64'd0);
    e0 = cyc + 1;
    start6 = 1; init6 = 48'h616161616161; tgt6 = c_md5_aaaaaa;
    sb.push_back('{dut: 0, edge_n: e0 + 67, found: 1'b1, msg: 64'h616161616161});
    @(negedge Clk);
    start6 = 0; abort6 = 0;
    wait_drain(200);

    // Asynchronous reset mid-search
    issue(0, 64'h616161616161, 128'd0, 0, 0, 1'b0, 64'd0, e0);
    wait_until(e0 + 199);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", {63'd0, busy6}, 64'd0);
    chk("arst_found", {63'd0, found6}, 64'd0);
    chk("arst_match_msg", {16'd0, msg6}, 64'd0);
    @(negedge Clk);
    rst_n = 1;
    @(negedge Clk);
    issue(0, 64'h616161616161, c_md5_aaaaaa, 1, 0, 1'b1, 64'h616161616161, e0);
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md5_search_engine.md
# md5_search_engine

Iterative, parametrised MD5 preimage search engine. It enumerates candidate messages of length MSG_LEN over a configurable character range. For each candidate it runs one MD5 step per clock (64 steps), adds the IV, and compares the digest against a runtime-loaded target. It stops on a match or when the range is exhausted. Multiple instances sit side by side in the top level, each given a different starting candidate to partition the key space.

## Interface
- MSG_LEN, 6 — candidate length in bytes; legal range 1..8.
- CHAR_MIN, 8'h61 — lowest character value ('a').
- CHAR_MAX, 8'h7a — highest character value ('z'); must be ≥ CHAR_MIN.
- Clk  in  1  — system clock; all state updates on the rising edge.
- Rst_n  in  1  — asynchronous, active-low reset.
- start  in  1  — one-cycle request; starts a search from init_msg.
- abort  in  1  — cancels a running search.
- init_msg  in  8*MSG_LEN  — first candidate; byte j in bits [8j+7:8j]; every byte must lie in [CHAR_MIN, CHAR_MAX].
- target  in  128  — digest words: A in [31:0], B in [63:32], C in [95:64], D in [127:96] (MD5 word order, little-endian byte packing).
- busy  out  1  — high in every state except IDLE.
- done  out  1  — one-cycle pulse when a search ends by match or exhaustion.
- found  out  1  — level; high when the last search matched.
- match_msg  out  8*MSG_LEN  — matching candidate; if no match, the last candidate tested.

## Operation
- **Message block (LOAD):** built from the current candidate.
  - Candidate byte j goes to block byte j; word w = bytes 4w..4w+3, with byte 4w in bits [7:0].
  - Byte MSG_LEN = 8'h80; all other bytes zero.
  - X14 = MSG_LEN*8; X15 = 0.
- **Step i (0..63):** standard MD5.
  - Functions: F for i 0..15, G for 16..31, H for 32..47, I for 48..63.
  - Message index g = i, (5i+1) mod 16, (3i+5) mod 16, 7i mod 16 for the four rounds respectively.
  - Constant: T[i] from the standard sine table.
  - Shift s: rows {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}, indexed by i mod 4.
  - Update: B' = B + rotl(A + f(B,C,D) + X[g] + T[i], s); A'=D, C'=B, D'=C.
  - All arithmetic is modulo 2^32.
- **IV:** 67452301, efcdab89, 98badcfe, 10325476. CHECK compares (A+IV_A, …, D+IV_D) with the latched target, all four words.
- **State machine:**
  - IDLE: on start, latch target and init_msg, then go to LOAD. abort is ignored here.
  - LOAD: init A..D to the IV, build the block, step counter := 0, then go to ROUND.
  - ROUND: one step per cycle; on step 63 go to CHECK.
  - CHECK, on match: found := 1, match_msg := candidate, go to DONE.
  - CHECK, no match, last candidate: found := 0, match_msg := candidate, go to DONE.
  - CHECK, no match, otherwise: increment the candidate, go to LOAD.
  - DONE: done = 1 for this single cycle, then go to IDLE.
- **Candidate increment:** odometer with byte 0 least significant. A byte equal to CHAR_MAX wraps to CHAR_MIN and carries; any other byte does +1. The last candidate is the one with all bytes equal to CHAR_MAX.
- **start while busy:** ignored.
- **abort while busy:** go to IDLE on the next edge. done is not pulsed; found and match_msg are unchanged.
- **start and abort in the same IDLE cycle:** start wins.
- **found:** cleared when a new start is accepted.

## Timing
- Reset values: busy=0, done=0, found=0, match_msg=0, state=IDLE.
- Reset is asynchronous; assertion mid-search returns to IDLE immediately, and no done pulse is generated.
- Per-candidate cost: 66 cycles (1 LOAD, 64 ROUND, 1 CHECK).
- Latency: with start sampled at edge 0, candidate k (0-based) ends in CHECK at edge 66+66k. done is high in the cycle following that edge, i.e. sampled high at edge 67+66k.
- found and match_msg are valid from the cycle done is high and stay stable until the next accepted start.
- busy is high from edge 1 through the DONE cycle inclusive.

## Test plan
- **Direct hit:** MSG_LEN=6, init_msg="aaaaaa", target A=0e7a4e0b B=d34ae85f C=5bf9b55f D=79acee9c → done at edge 67, found=1, match_msg="aaaaaa".
- **Search hit:** MSG_LEN=3, init_msg="aaa", target A=98500190 B=b04fd23c C=7d3f96d6 D=727fe128 ("abc", k=1378) → done at edge 67+66·1378=91015, found=1, match_msg="abc".
- **Exhaustion:** MSG_LEN=1, init_msg="a", target=0 → 26 candidates tested; done at edge 1717, found=0, match_msg="z".
- **Single-char hit:** MSG_LEN=1, init_msg="a", target A=b975c10c B=a8b6f1c0 C=e299c331 D=61267769 → done at edge 67, found=1.
- **Abort and ignored start:** abort at edge 500 of a search → IDLE at edge 501, no done pulse, found unchanged. A start pulse during ROUND has no effect on timing or results.
- **Reset mid-search:** Rst_n low at edge 200 → busy=0, found=0, match_msg=0 immediately. A new start afterwards produces the direct-hit result unchanged.
